// File: rtl/vx_tcu_lsu_responder_pkg.sv
// Shared tensor-core types and defaults for the TCU load/store responder.
package vx_tcu_lsu_responder_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned TCU_REQ_DEPTH   = 4;
    localparam int unsigned TCU_MAX_PENDING = 4;

    // One request-queue entry as accepted from the tensor core.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            load;
        logic [XLEN-1:0] wdata;
    } tcu_req_t;

endpackage

// File: rtl/vx_tcu_lsu_responder_fifo_queue.sv
// In-order request queue; DEPTH must be a power of two so pointers wrap naturally.
module vx_tcu_lsu_responder_fifo_queue
    import vx_tcu_lsu_responder_pkg::*;
#(
    parameter int unsigned DEPTH = TCU_REQ_DEPTH
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  tcu_req_t wdata,
    output tcu_req_t rdata,
    output logic     empty,
    output logic     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

    tcu_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_MAX);
    // A push into a full queue is refused even if the head leaves this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (!do_push && do_pop) count_q <= count_q - CNT_ONE;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vx_tcu_lsu_responder.sv
// Bridges tensor-core loads/stores to memory: queues requests, issues them in order
// with rolling tags, and returns load data through a one-entry response buffer.
module vx_tcu_lsu_responder
    import vx_tcu_lsu_responder_pkg::*;
#(
    parameter int unsigned REQ_DEPTH   = TCU_REQ_DEPTH,
    parameter int unsigned MAX_PENDING = TCU_MAX_PENDING,
    localparam int unsigned TAG_W      = $clog2(MAX_PENDING)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tcu_ready,
    input  logic [XLEN-1:0] tcu_addr,
    input  logic            tcu_load,
    input  logic [XLEN-1:0] tcu_wdata,
    output logic            tcu_valid,
    output logic            tcu_rsp_valid,
    output logic [XLEN-1:0] tcu_rsp_data,
    input  logic            tcu_rsp_ready,
    output logic            mem_req_valid,
    output logic            mem_req_rw,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_data,
    output logic [TAG_W-1:0] mem_req_tag,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic [TAG_W-1:0] mem_rsp_tag,
    output logic            mem_rsp_ready,
    output logic            tag_err
);

    localparam logic [TAG_W:0]   PEND_MAX = (TAG_W+1)'(MAX_PENDING);
    localparam logic [TAG_W:0]   PEND_ONE = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] TAG_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};

    tcu_req_t        push_entry, head;
    logic            q_empty, q_full;
    logic            mem_fire, load_issue, rsp_fire, rsp_accept;
    logic [TAG_W:0]  pending_q, pending_d;
    logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
    logic [TAG_W-1:0] exp_tag_q, exp_tag_d;
    logic            tag_err_q, tag_err_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;

    assign push_entry = '{addr: tcu_addr, load: tcu_load, wdata: tcu_wdata};
    // Gated by reset so nothing is acknowledged while the block is held in reset.
    assign tcu_valid  = reset & tcu_ready & ~q_full;

    vx_tcu_lsu_responder_fifo_queue #(
        .DEPTH (REQ_DEPTH)
    ) u_req_queue (
        .clk   (clk),
        .reset (reset),
        .push  (tcu_valid),
        .pop   (mem_fire),
        .wdata (push_entry),
        .rdata (head),
        .empty (q_empty),
        .full  (q_full)
    );

    // Stores never wait on the pending limit since they produce no response.
    assign mem_req_valid = ~q_empty & (~head.load | (pending_q < PEND_MAX));
    assign mem_req_rw    = ~head.load;
    assign mem_req_addr  = head.addr;
    assign mem_req_data  = head.wdata;
    assign mem_req_tag   = head.load ? issue_tag_q : '0;
    assign mem_fire      = mem_req_valid & mem_req_ready;
    assign load_issue    = mem_fire & head.load;

    assign mem_rsp_ready = ~rsp_valid_q | tcu_rsp_ready;
    assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;
    // Responses with nothing outstanding (e.g. for requests lost to reset) are dropped.
    assign rsp_accept    = rsp_fire & (pending_q != '0);

    assign tcu_rsp_valid = rsp_valid_q;
    assign tcu_rsp_data  = rsp_data_q;
    assign tag_err       = tag_err_q;

    // Next-state for tag/pending bookkeeping and the response buffer.
    always_comb begin
        pending_d   = pending_q;
        issue_tag_d = issue_tag_q;
        exp_tag_d   = exp_tag_q;
        tag_err_d   = tag_err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        if (load_issue) issue_tag_d = issue_tag_q + TAG_ONE;

        if (load_issue && !rsp_accept)      pending_d = pending_q + PEND_ONE;
        else if (!load_issue && rsp_accept) pending_d = pending_q - PEND_ONE;

        if (rsp_fire && !rsp_accept) tag_err_d = 1'b1;

        if (rsp_accept) begin
            exp_tag_d   = exp_tag_q + TAG_ONE;
            if (mem_rsp_tag != exp_tag_q) tag_err_d = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_rsp_data;
        end else if (tcu_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            issue_tag_q <= '0;
            exp_tag_q   <= '0;
            tag_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            issue_tag_q <= issue_tag_d;
            exp_tag_q   <= exp_tag_d;
            tag_err_q   <= tag_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_vx_tcu_lsu_responder.sv
// Scoreboard bench for vx_tcu_lsu_responder.
module tb_vx_tcu_lsu_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tcu_ready = 1'b0, tcu_load = 1'b0, tcu_valid;
    logic [31:0] tcu_addr = '0, tcu_wdata = '0;
    logic        tcu_rsp_valid, tcu_rsp_ready = 1'b0;
    logic [31:0] tcu_rsp_data;
    logic        mem_req_valid, mem_req_rw, mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [1:0]  mem_req_tag, mem_rsp_tag = '0;
    logic        mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [31:0] mem_rsp_data = '0;
    logic        tag_err;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] data;
        logic [1:0]  tag;
    } req_exp_t;

    req_exp_t    exp_req[$];
    logic [31:0] exp_rsp[$];
    int total = 0, bad = 0;
    int load_cnt = 0, rsp_tag = 0;

    vx_tcu_lsu_responder dut (
        .clk           (clk),
        .reset         (reset),
        .tcu_ready     (tcu_ready),
        .tcu_addr      (tcu_addr),
        .tcu_load      (tcu_load),
        .tcu_wdata     (tcu_wdata),
        .tcu_valid     (tcu_valid),
        .tcu_rsp_valid (tcu_rsp_valid),
        .tcu_rsp_data  (tcu_rsp_data),
        .tcu_rsp_ready (tcu_rsp_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_tag   (mem_req_tag),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_tag   (mem_rsp_tag),
        .mem_rsp_ready (mem_rsp_ready),
        .tag_err       (tag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled on the falling edge, inputs change 1 unit after the rising edge.
    always @(negedge clk) begin
        if (reset && mem_req_valid && mem_req_ready) begin
            if (exp_req.size() == 0) check("req_unexpected", 1, 0);
            else begin
                req_exp_t e;
                e = exp_req.pop_front();
                check("req_addr", mem_req_addr, e.addr);
                check("req_rw", mem_req_rw, e.rw);
                check("req_tag", mem_req_tag, e.tag);
                if (e.rw) check("req_data", mem_req_data, e.data);
            end
        end
        if (reset && tcu_rsp_valid && tcu_rsp_ready) begin
            if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_data_sb", tcu_rsp_data, exp_rsp.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_req(input logic [31:0] a, input logic ld, input logic [31:0] wd,
                           output int waited);
        req_exp_t e;
        int n = 0;
        tcu_ready = 1'b1; tcu_addr = a; tcu_load = ld; tcu_wdata = wd;
        @(negedge clk);
        while (!tcu_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", tcu_valid, 1);
        e.addr = a; e.rw = ~ld; e.data = wd;
        e.tag  = ld ? 2'(load_cnt % 4) : 2'd0;
        if (ld) load_cnt++;
        exp_req.push_back(e);
        waited = n;
        @(posedge clk); #1;
        tcu_ready = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] d, input logic [1:0] t, input logic fwd);
        int n = 0;
        mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_tag = t;
        @(negedge clk);
        while (!mem_rsp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rsp_ready", mem_rsp_ready, 1);
        if (fwd) exp_rsp.push_back(d);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        if (fwd) begin
            check("rsp_latency", tcu_rsp_valid, 1);
            check("rsp_data", tcu_rsp_data, d);
        end
    endtask

    task automatic send_ok(input logic [31:0] d);
        send_rsp(d, 2'(rsp_tag % 4), 1'b1);
        rsp_tag++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_req.delete(); exp_rsp.delete();
        load_cnt = 0; rsp_tag = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        // Reset state, with a request presented to confirm tcu_valid stays low.
        tcu_ready = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_tcu_valid", tcu_valid, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_rsp_valid", tcu_rsp_valid, 0);
        check("rst_rsp_data", tcu_rsp_data, 0);
        check("rst_tag_err", tag_err, 0);
        @(negedge clk) begin reset = 1'b1; tcu_ready = 1'b0; end
        @(posedge clk); #1;

        // Single load round trip.
        mem_req_ready = 1'b1; tcu_rsp_ready = 1'b1;
        put_req(32'h1000, 1'b1, 32'h0, w);
        check("t1_same_cycle", w, 0);
        idle(2);
        send_ok(32'hCAFE);
        idle(2);

        // Queue fill with memory stalled; full+pop cycle must not push.
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_req(32'h3000 + 32'(i * 4), 1'b0, 32'(i), w);
        tcu_ready = 1'b1; tcu_addr = 32'h3010; tcu_load = 1'b0; tcu_wdata = 32'h4;
        @(negedge clk) check("full_block", tcu_valid, 0);
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(negedge clk) check("full_pop_no_push", tcu_valid, 0);
        @(posedge clk); #1;
        put_req(32'h3010, 1'b0, 32'h4, w);
        put_req(32'h3014, 1'b0, 32'h5, w);
        idle(6);
        check("fill_drained", exp_req.size(), 0);

        // Pending limit and tag wrap.
        do_reset();
        for (int i = 0; i < 5; i++) put_req(32'h4000 + 32'(i * 4), 1'b1, 32'h0, w);
        idle(3);
        check("pend_limit_hold", mem_req_valid, 0);
        check("pend_limit_left", exp_req.size(), 1);
        send_ok(32'hA0);
        idle(3);
        check("pend_fifth_issued", exp_req.size(), 0);
        for (int i = 1; i < 5; i++) send_ok(32'hA0 + 32'(i));
        idle(2);
        check("wrap_no_err", tag_err, 0);

        // Store: no response, no pending slot consumed.
        put_req(32'h2000, 1'b0, 32'h55, w);
        idle(3);
        check("store_no_rsp", tcu_rsp_valid, 0);
        for (int i = 0; i < 4; i++) put_req(32'h6000 + 32'(i * 4), 1'b1, 32'h0, w);
        idle(4);
        check("store_pend_free", exp_req.size(), 0);
        for (int i = 0; i < 4; i++) send_ok(32'hB0 + 32'(i));
        idle(2);

        // Tag mismatch: data forwarded, error sticky.
        do_reset();
        put_req(32'h5000, 1'b1, 32'h0, w);
        idle(2);
        send_rsp(32'hBEEF, 2'd2, 1'b1);
        rsp_tag++;
        check("tag_err_set", tag_err, 1);
        put_req(32'h5004, 1'b1, 32'h0, w);
        idle(2);
        send_ok(32'h1234);
        idle(2);
        check("tag_err_sticky", tag_err, 1);

        // Reset mid-operation with 3 loads outstanding and a buffered response.
        tcu_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_req(32'h7000 + 32'(i * 4), 1'b1, 32'h0, w);
        idle(2);
        send_ok(32'hD00D);
        idle(1);
        check("pre_rst_buffered", tcu_rsp_valid, 1);
        tcu_ready = 1'b1; tcu_load = 1'b1; tcu_addr = 32'h7100;
        #2 reset = 1'b0;
        #1;
        check("async_tcu_valid", tcu_valid, 0);
        check("async_mem_req_valid", mem_req_valid, 0);
        check("async_rsp_valid", tcu_rsp_valid, 0);
        check("async_rsp_data", tcu_rsp_data, 0);
        check("async_tag_err", tag_err, 0);
        exp_req.delete(); exp_rsp.delete();
        load_cnt = 0; rsp_tag = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) begin reset = 1'b1; tcu_ready = 1'b0; end
        @(posedge clk); #1;
        tcu_rsp_ready = 1'b1;
        send_rsp(32'h5A5A, 2'd3, 1'b0);
        idle(1);
        check("stale_dropped", tcu_rsp_valid, 0);
        check("stale_tag_err", tag_err, 1);
        put_req(32'h8000, 1'b1, 32'h0, w);
        idle(2);
        send_ok(32'h77);
        idle(3);
        check("end_req_empty", exp_req.size(), 0);
        check("end_rsp_empty", exp_rsp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
